// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset defaults and the packed fetch-entry layout used by fetch and decode.
package fetch_queue_pkg;

  localparam int unsigned FQ_ADDR_W   = 16;
  localparam int unsigned FQ_INST_W   = 32;
  localparam int unsigned FQ_DEPTH    = 4;
  localparam int unsigned FQ_RESET_PC = 0;

  localparam int unsigned FQ_ENTRY_W = FQ_ADDR_W + FQ_INST_W;

  // pc sits in the upper bits so decode can slice it the same way the fetch stage packs it.
  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (!flush && push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: sequential reads into 1-cycle imem, buffered for decode, flushed on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_W   = FQ_ADDR_W,
  parameter int unsigned INST_W   = FQ_INST_W,
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter int unsigned RESET_PC = FQ_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic [EW-1:0]     fifo_dout;
  logic              pop, push;
  logic [CW:0]       pending;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready & ~redirect;
  assign push      = inflight_q & ~redirect;

  // Credit: entries that will occupy the FIFO after this edge, counting the read already in flight.
  assign pending   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign imem_req  = reset & ~redirect & (pending < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;

  assign out_pc   = fifo_dout[EW-1:INST_W];
  assign out_inst = fifo_dout[INST_W-1:0];
  assign count    = fifo_count;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({inflight_pc_q, imem_inst}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
